// File: rtl/lu_pkg.sv
// Shared types and constants for the round-robin OR/NOR logic-unit scheduler.
package lu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OP_OR  = 1'b0;
  localparam logic OP_NOR = 1'b1;

  // Round-robin pick: on contention the requester that did not finish last wins.
  function automatic logic pick_winner(input logic r0, input logic r1, input logic last_id);
    logic win;
    if (r0 && r1) begin
      win = ~last_id;
    end else if (r0) begin
      win = 1'b0;
    end else begin
      win = 1'b1;
    end
    return win;
  endfunction

endpackage

// File: rtl/lu_rr_scheduler_if.sv
// Request/response bundle between the two requesters, the consumer and the scheduler.
interface lu_rr_scheduler_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) ();

  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             sel0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             sel1;
  logic             gnt0;
  logic             gnt1;
  logic             rsp_valid;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_y;
  logic             rsp_ready;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  // Requester / consumer side.
  modport master (
    output req0, a0, b0, sel0, req1, a1, b1, sel1, rsp_ready,
    input  gnt0, gnt1, rsp_valid, rsp_id, rsp_y, busy, op_count
  );

  // Scheduler side.
  modport slave (
    input  req0, a0, b0, sel0, req1, a1, b1, sel1, rsp_ready,
    output gnt0, gnt1, rsp_valid, rsp_id, rsp_y, busy, op_count
  );

endinterface

// File: rtl/lu_or_nor_word.sv
// Combinational WIDTH-bit logic unit: y = a|b, or its complement when sel selects NOR.
module lu_or_nor_word
  import lu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] or_s;

  // Bitwise OR, optionally inverted for the NOR operation.
  always_comb begin
    or_s = a | b;
    if (sel == OP_NOR) begin
      y = ~or_s;
    end else begin
      y = or_s;
    end
  end

endmodule

// File: rtl/lu_rr_scheduler.sv
// Round-robin scheduler sharing one OR/NOR logic unit between two requesters.
// One operation in flight: IDLE grants and captures, EXEC computes, RESP waits
// for the consumer handshake.
module lu_rr_scheduler
  import lu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  lu_rr_scheduler_if.slave    bus
);

  state_t           state_r;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             sel_r;
  logic             id_r;
  logic             last_id_r;

  logic             gnt0_r;
  logic             gnt1_r;
  logic             rsp_valid_r;
  logic             rsp_id_r;
  logic [WIDTH-1:0] rsp_y_r;
  logic             busy_r;
  logic [CNT_W-1:0] op_count_r;

  logic             grant_s;
  logic             win_id_s;
  logic             load_rsp_s;
  logic             done_s;
  logic [WIDTH-1:0] win_a_s;
  logic [WIDTH-1:0] win_b_s;
  logic             win_sel_s;
  logic [WIDTH-1:0] y_s;

  lu_or_nor_word #(.WIDTH(WIDTH)) u_unit (
    .a   (a_r),
    .b   (b_r),
    .sel (sel_r),
    .y   (y_s)
  );

  // Next-state and control strobes; requests are only looked at in IDLE.
  always_comb begin
    state_nxt  = state_r;
    grant_s    = 1'b0;
    win_id_s   = 1'b0;
    load_rsp_s = 1'b0;
    done_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant_s   = 1'b1;
          win_id_s  = pick_winner(bus.req0, bus.req1, last_id_r);
          state_nxt = EXEC;
        end else begin
          state_nxt = IDLE;
        end
      end
      EXEC: begin
        load_rsp_s = 1'b1;
        state_nxt  = RESP;
      end
      RESP: begin
        if (rsp_valid_r && bus.rsp_ready) begin
          done_s    = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = RESP;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand mux selecting the winning requester's inputs.
  always_comb begin
    win_a_s   = {WIDTH{1'b0}};
    win_b_s   = {WIDTH{1'b0}};
    win_sel_s = 1'b0;
    if (win_id_s) begin
      win_a_s   = bus.a1;
      win_b_s   = bus.b1;
      win_sel_s = bus.sel1;
    end else begin
      win_a_s   = bus.a0;
      win_b_s   = bus.b0;
      win_sel_s = bus.sel0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Operand capture on the granting edge; later operand changes cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= {WIDTH{1'b0}};
      b_r   <= {WIDTH{1'b0}};
      sel_r <= 1'b0;
      id_r  <= 1'b0;
    end else if (grant_s) begin
      a_r   <= win_a_s;
      b_r   <= win_b_s;
      sel_r <= win_sel_s;
      id_r  <= win_id_s;
    end
  end

  // Grant pulses and busy flag, registered from the next-cycle decisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0_r <= 1'b0;
      gnt1_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      gnt0_r <= grant_s && !win_id_s;
      gnt1_r <= grant_s && win_id_s;
      busy_r <= (state_nxt != IDLE);
    end
  end

  // Response register: loaded after EXEC, held through backpressure, kept after handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 1'b0;
      rsp_y_r     <= {WIDTH{1'b0}};
    end else if (load_rsp_s) begin
      rsp_valid_r <= 1'b1;
      rsp_id_r    <= id_r;
      rsp_y_r     <= y_s;
    end else if (done_s) begin
      rsp_valid_r <= 1'b0;
    end
  end

  // Fairness pointer and completed-operation counter, updated on the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id_r  <= 1'b1;
      op_count_r <= {CNT_W{1'b0}};
    end else if (done_s) begin
      last_id_r  <= rsp_id_r;
      op_count_r <= op_count_r + CNT_W'(1);
    end
  end

  assign bus.gnt0      = gnt0_r;
  assign bus.gnt1      = gnt1_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_y     = rsp_y_r;
  assign bus.busy      = busy_r;
  assign bus.op_count  = op_count_r;

endmodule

// File: tb/tb_lu_rr_scheduler.sv
// Self-checking bench for lu_rr_scheduler: vector table plus hand-written
// sequences, with responses checked against a scoreboard queue.
module tb_lu_rr_scheduler;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  lu_rr_scheduler_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  lu_rr_scheduler #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       id;
    logic [3:0] y;
  } exp_t;

  typedef struct {
    logic       r0;
    logic [3:0] a0;
    logic [3:0] b0;
    logic       s0;
    logic       r1;
    logic [3:0] a1;
    logic [3:0] b1;
    logic       s1;
    logic       exp_id;
    logic [3:0] exp_y;
  } vec_t;

  exp_t       sb_q[$];
  vec_t       vecs[7];
  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] exp_count;

  function automatic logic [3:0] lu_model(input logic [3:0] a, input logic [3:0] b, input logic s);
    return s ? ~(a | b) : (a | b);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Scoreboard: each accepted response is popped and compared.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (sb_q.size() == 0) begin
        timeout_fail("unexpected_rsp");
      end else begin
        e = sb_q.pop_front();
        check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
        check("rsp_y", 32'(bus.rsp_y), 32'(e.y));
        exp_count++;
      end
    end
  end

  task automatic drive_idle();
    bus.req0 = 1'b0; bus.a0 = 4'd0; bus.b0 = 4'd0; bus.sel0 = 1'b0;
    bus.req1 = 1'b0; bus.a1 = 4'd0; bus.b1 = 4'd0; bus.sel1 = 1'b0;
    bus.rsp_ready = 1'b1;
  endtask

  task automatic reset_dut();
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    exp_count = 8'd0;
  endtask

  task automatic wait_gnt(output logic [1:0] g, output int cyc);
    g = 2'b00;
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.gnt0 || bus.gnt1) begin
        g = {bus.gnt1, bus.gnt0};
        break;
      end
    end
    if (g == 2'b00) timeout_fail("gnt_wait");
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (bus.busy && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    if (bus.busy) timeout_fail("idle_wait");
  endtask

  task automatic run_vec(input vec_t v);
    logic [1:0] g;
    int         cyc;
    exp_t       e;
    @(negedge clk);
    bus.req0 = v.r0; bus.a0 = v.a0; bus.b0 = v.b0; bus.sel0 = v.s0;
    bus.req1 = v.r1; bus.a1 = v.a1; bus.b1 = v.b1; bus.sel1 = v.s1;
    e.id = v.exp_id;
    e.y  = v.exp_y;
    sb_q.push_back(e);
    wait_gnt(g, cyc);
    check("gnt_id", 32'(g), 32'(v.exp_id ? 2'b10 : 2'b01));
    check("gnt_latency", 32'(cyc), 32'd1);
    check("busy_exec", 32'(bus.busy), 32'd1);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = ~v.a0; bus.b0 = ~v.b0; bus.sel0 = ~v.s0;
    bus.a1 = ~v.a1; bus.b1 = ~v.b1; bus.sel1 = ~v.s1;
    @(negedge clk);
    check("gnt_pulse", 32'({bus.gnt1, bus.gnt0}), 32'd0);
    check("rsp_valid_lat", 32'(bus.rsp_valid), 32'd1);
    wait_idle();
    check("op_count", 32'(bus.op_count), 32'(exp_count));
  endtask

  // Global watchdog.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] g;
    int         cyc;
    exp_t       e;
    logic       ghost;

    //           r0   a0       b0       s0    r1    a1       b1       s1    id    y
    vecs[0] = '{1'b1, 4'b0101, 4'b0011, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0111};
    vecs[1] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0101, 4'b0011, 1'b1, 1'b1, 4'b1000};
    vecs[2] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000};
    vecs[3] = '{1'b1, 4'b1111, 4'b0000, 1'b1, 1'b1, 4'b1000, 4'b0001, 1'b0, 1'b1, 4'b1001};
    vecs[4] = '{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1111};
    vecs[5] = '{1'b1, 4'b1010, 4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1110};
    vecs[6] = '{1'b1, 4'b0001, 4'b0001, 1'b0, 1'b1, 4'b0011, 4'b0100, 1'b1, 1'b1, 4'b1000};

    // Reset state, with rsp_ready high in IDLE.
    reset_dut();
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_rsp_y", 32'(bus.rsp_y), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_op_count", 32'(bus.op_count), 32'd0);

    // Table-driven single operations.
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Contention from reset: both held, grants 0,1,0,1 three cycles apart.
    reset_dut();
    @(negedge clk);
    bus.req0 = 1'b1; bus.a0 = 4'b1100; bus.b0 = 4'b0001; bus.sel0 = 1'b0;
    bus.req1 = 1'b1; bus.a1 = 4'b0110; bus.b1 = 4'b0000; bus.sel1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(g, cyc);
      check("rr_order", 32'(g), 32'(k[0] ? 2'b10 : 2'b01));
      if (k > 0) check("rr_spacing", 32'(cyc), 32'd3);
      e.id = k[0];
      e.y  = k[0] ? lu_model(bus.a1, bus.b1, bus.sel1) : lu_model(bus.a0, bus.b0, bus.sel0);
      sb_q.push_back(e);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    wait_idle();
    check("rr_op_count", 32'(bus.op_count), 32'(exp_count));

    // Backpressure: five stalled cycles in RESP with requester 1 waiting.
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req0 = 1'b1; bus.a0 = 4'b0110; bus.b0 = 4'b1001; bus.sel0 = 1'b0;
    bus.req1 = 1'b1; bus.a1 = 4'b0010; bus.b1 = 4'b0100; bus.sel1 = 1'b0;
    e.id = 1'b0; e.y = 4'b1111; sb_q.push_back(e);
    e.id = 1'b1; e.y = 4'b0110; sb_q.push_back(e);
    wait_gnt(g, cyc);
    check("bp_gnt", 32'(g), 32'b01);
    bus.req0 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_y", 32'(bus.rsp_y), 32'b1111);
      check("bp_id", 32'(bus.rsp_id), 32'd0);
      check("bp_busy", 32'(bus.busy), 32'd1);
      check("bp_no_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    wait_gnt(g, cyc);
    check("bp_next_gnt", 32'(g), 32'b10);
    check("bp_next_lat", 32'(cyc), 32'd2);
    bus.req1 = 1'b0;
    wait_idle();
    check("bp_op_count", 32'(bus.op_count), 32'(exp_count));

    // Reset in EXEC: outputs clear at once, the operation is discarded.
    @(negedge clk);
    bus.req0 = 1'b1; bus.a0 = 4'b0001; bus.b0 = 4'b0010; bus.sel0 = 1'b0;
    wait_gnt(g, cyc);
    bus.req0 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);
    check("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_count", 32'(bus.op_count), 32'd0);
    check("mid_rst_y", 32'(bus.rsp_y), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    exp_count = 8'd0;
    ghost = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.gnt0 || bus.gnt1 || bus.busy) ghost = 1'b1;
    end
    check("no_ghost_op", 32'(ghost), 32'd0);
    @(negedge clk);
    bus.req0 = 1'b1; bus.a0 = 4'b0011; bus.b0 = 4'b0000; bus.sel0 = 1'b1;
    bus.req1 = 1'b1; bus.a1 = 4'b0000; bus.b1 = 4'b0000; bus.sel1 = 1'b0;
    e.id = 1'b0; e.y = 4'b1100; sb_q.push_back(e);
    wait_gnt(g, cyc);
    check("post_rst_gnt", 32'(g), 32'b01);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    wait_idle();
    check("post_rst_count", 32'(bus.op_count), 32'd1);

    // Counter wrap: 256 back-to-back ops, operands changed right after each grant.
    reset_dut();
    @(negedge clk);
    bus.req0 = 1'b1;
    bus.a0 = 4'($urandom); bus.b0 = 4'($urandom); bus.sel0 = 1'($urandom);
    for (int k = 0; k < 256; k++) begin
      wait_gnt(g, cyc);
      if (g != 2'b01) check("wrap_gnt", 32'(g), 32'b01);
      if (k == 1) check("b2b_spacing", 32'(cyc), 32'd3);
      if (k == 255) check("count_255", 32'(bus.op_count), 32'd255);
      e.id = 1'b0;
      e.y  = lu_model(bus.a0, bus.b0, bus.sel0);
      sb_q.push_back(e);
      bus.a0 = 4'($urandom); bus.b0 = 4'($urandom); bus.sel0 = 1'($urandom);
    end
    bus.req0 = 1'b0;
    wait_idle();
    check("count_wrap", 32'(bus.op_count), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
